// File: rtl/piso_stream.sv
`timescale 1ns/1ps
// piso_stream: parallel word in, one serial bit per transfer out, valid/ready on both sides.
// Latency 1 cycle from acceptance to first bit; dout_ready=0 freezes all state and outputs.
// Build macro PISO_STREAM_PARITY_EN appends an even-parity bit as the final frame bit.
module piso_stream #(
    parameter int DATA_WIDTH = 16,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    input  logic                  dout_ready
);

`ifdef PISO_STREAM_PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
    logic [FRAME_LEN-1:0]   frame_load;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   cur_bit;
    logic                   is_last;
    logic                   xfer;
    logic                   accept;

    // The parity bit sits at the end of the shift direction so it leaves last.
`ifdef PISO_STREAM_PARITY_EN
    always_comb begin
        if (LSB_FIRST) begin
            frame_load = {^din, din};
        end else begin
            frame_load = {din, ^din};
        end
    end
`else
    assign frame_load = din;
`endif

    assign cur_bit    = LSB_FIRST ? shreg_q[0] : shreg_q[FRAME_LEN-1];
    assign dout_valid = (state_q == SHIFT);
    assign dout       = dout_valid & cur_bit;
    assign is_last    = dout_valid && (cnt_q == LAST_IDX);
    assign dout_last  = is_last;
    assign xfer       = dout_valid && dout_ready;
    // Gated by resetn so upstream never sees ready while the block is held in reset.
    assign din_ready  = resetn && ((state_q == IDLE) || (dout_ready && is_last));
    assign accept     = din_valid && din_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = frame_load;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (is_last) begin
                        if (accept) begin
                            shreg_d = frame_load;
                            cnt_d   = '0;
                        end else begin
                            state_d = IDLE;
                            shreg_d = '0;
                            cnt_d   = '0;
                        end
                    end else begin
                        shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
`timescale 1ns/1ps
// Bench for piso_stream: an LSB-first and an MSB-first instance share stimulus and are
// checked cycle by cycle against a frame-level reference model.
module tb_piso_stream;

`ifdef PISO_STREAM_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk;
    logic       resetn;
    logic [7:0] din;
    logic       din_valid;
    logic       dout_ready;
    logic       din_ready_l, dout_l, dout_valid_l, dout_last_l;
    logic       din_ready_m, dout_m, dout_valid_m, dout_last_m;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] word_q[$];
    bit         rdy_pat[$];
    logic [63:0] s_l, s_m;
    int         n_xfer;

    piso_stream #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_l), .dout(dout_l), .dout_valid(dout_valid_l),
        .dout_last(dout_last_l), .dout_ready(dout_ready)
    );

    piso_stream #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_m), .dout(dout_m), .dout_valid(dout_valid_m),
        .dout_last(dout_last_m), .dout_ready(dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit 'pos' of the serial frame for word w; position 8 is the even-parity bit.
    function automatic logic frame_bit(input logic [7:0] w, input int pos, input bit lsb);
        if (pos >= 8) return ^w;
        return lsb ? w[pos] : w[7-pos];
    endfunction

    task automatic run_words(input int rdy_pct, input bit hold_valid, input int max_cycles,
                             output int cycles);
        bit         busy = 1'b0;
        bit         offered = 1'b0;
        int         pos = 0;
        logic [7:0] cur = '0;
        bit         exp_last, exp_rdy;
        logic [3:0] exp_l, exp_m;
        cycles = 0;
        n_xfer = 0;
        s_l = '0;
        s_m = '0;
        while ((word_q.size() > 0 || busy) && cycles < max_cycles) begin
            if (!offered && word_q.size() > 0)
                offered = hold_valid || ($urandom_range(0, 99) < 60);
            din_valid = offered;
            din = offered ? word_q[0] : 8'($urandom);
            if (rdy_pat.size() > 0) dout_ready = rdy_pat.pop_front();
            else dout_ready = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clk);
            exp_last = busy && (pos == FL - 1);
            exp_rdy  = !busy || (dout_ready && exp_last);
            exp_l = {exp_rdy, busy, busy && frame_bit(cur, pos, 1'b1), exp_last};
            exp_m = {exp_rdy, busy, busy && frame_bit(cur, pos, 1'b0), exp_last};
            n_checks++;
            if ({din_ready_l, dout_valid_l, dout_l, dout_last_l} !== exp_l)
                $display("FAIL lsb_cycle t=%0t rdy/vld/dat/last got %b want %b", $time,
                         {din_ready_l, dout_valid_l, dout_l, dout_last_l}, exp_l);
            else n_pass++;
            n_checks++;
            if ({din_ready_m, dout_valid_m, dout_m, dout_last_m} !== exp_m)
                $display("FAIL msb_cycle t=%0t rdy/vld/dat/last got %b want %b", $time,
                         {din_ready_m, dout_valid_m, dout_m, dout_last_m}, exp_m);
            else n_pass++;
            if (busy && dout_ready) begin
                if (n_xfer < 64) begin
                    s_l[n_xfer] = dout_l;
                    s_m[n_xfer] = dout_m;
                end
                n_xfer++;
                if (exp_last) busy = 1'b0;
                else pos++;
            end
            if (din_valid && exp_rdy) begin
                cur = word_q.pop_front();
                busy = 1'b1;
                pos = 0;
                offered = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        if (word_q.size() > 0 || busy) begin
            n_checks++;
            $display("FAIL run_timeout cycles=%0d pending_words=%0d required completion",
                     cycles, word_q.size());
            word_q.delete();
        end
        din_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({din_ready_l, dout_valid_l, dout_l, dout_last_l, din_ready_m, dout_valid_m,
             dout_m, dout_last_m} !== 8'b1000_1000)
            $display("FAIL idle_after_run got %b want 10001000",
                     {din_ready_l, dout_valid_l, dout_l, dout_last_l,
                      din_ready_m, dout_valid_m, dout_m, dout_last_m});
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        din = '0;
        din_valid = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({din_ready_l, dout_valid_l, dout_l, dout_last_l, din_ready_m, dout_valid_m,
             dout_m, dout_last_m} !== 8'h00)
            $display("FAIL reset_outputs got %b want 00000000",
                     {din_ready_l, dout_valid_l, dout_l, dout_last_l,
                      din_ready_m, dout_valid_m, dout_m, dout_last_m});
        else n_pass++;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({din_ready_l, dout_valid_l, din_ready_m, dout_valid_m} !== 4'b1010)
            $display("FAIL reset_release_ready got %b want 1010",
                     {din_ready_l, dout_valid_l, din_ready_m, dout_valid_m});
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_c1();
        int cyc;
        logic [63:0] want_l, want_m;
`ifdef PISO_STREAM_PARITY_EN
        want_l = 64'h1C1;
        want_m = 64'h183;
`else
        want_l = 64'hC1;
        want_m = 64'h83;
`endif
        word_q.push_back(8'hC1);
        run_words(100, 1'b1, 100, cyc);
        n_checks++;
        if (cyc !== FL + 1) $display("FAIL c1_latency cycles got %0d want %0d", cyc, FL + 1);
        else n_pass++;
        n_checks++;
        if (s_l !== want_l) $display("FAIL c1_lsb_stream got %h want %h", s_l, want_l);
        else n_pass++;
        n_checks++;
        if (s_m !== want_m) $display("FAIL c1_msb_stream got %h want %h", s_m, want_m);
        else n_pass++;
    endtask

    task automatic test_stall();
        int cyc;
        word_q.push_back(8'hC1);
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run_words(100, 1'b1, 100, cyc);
        n_checks++;
        if (cyc !== FL + 4) $display("FAIL stall_cycles got %0d want %0d", cyc, FL + 4);
        else n_pass++;
        n_checks++;
        if (s_l[7:0] !== 8'hC1 || n_xfer !== FL)
            $display("FAIL stall_stream got %h/%0d want c1/%0d", s_l[7:0], n_xfer, FL);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [63:0] want_l, want_m;
`ifdef PISO_STREAM_PARITY_EN
        want_l = 64'({1'b0, 8'h3C, 1'b1, 8'hC1});
        want_m = 64'({1'b0, 8'h3C, 1'b1, 8'h83});
`else
        want_l = 64'({8'h3C, 8'hC1});
        want_m = 64'({8'h3C, 8'h83});
`endif
        word_q.push_back(8'hC1);
        word_q.push_back(8'h3C);
        run_words(100, 1'b1, 200, cyc);
        n_checks++;
        if (cyc !== 2 * FL + 1) $display("FAIL b2b_cycles got %0d want %0d", cyc, 2 * FL + 1);
        else n_pass++;
        n_checks++;
        if (s_l !== want_l || s_m !== want_m)
            $display("FAIL b2b_stream got %h/%h want %h/%h", s_l, s_m, want_l, want_m);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        din = 8'hC1;
        din_valid = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if ({din_ready_l, dout_valid_l, dout_l, dout_last_l, din_ready_m, dout_valid_m,
             dout_m, dout_last_m} !== 8'h00)
            $display("FAIL midframe_reset_outputs got %b want 00000000",
                     {din_ready_l, dout_valid_l, dout_l, dout_last_l,
                      din_ready_m, dout_valid_m, dout_m, dout_last_m});
        else n_pass++;
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({din_ready_l, dout_valid_l, dout_l, din_ready_m, dout_valid_m, dout_m} !== 6'b100100)
                $display("FAIL midframe_residual i=%0d got %b want 100100", i,
                         {din_ready_l, dout_valid_l, dout_l, din_ready_m, dout_valid_m, dout_m});
            else n_pass++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int cyc;
        for (int i = 0; i < 25; i++) word_q.push_back(8'($urandom));
        run_words(70, 1'b0, 3000, cyc);
        for (int i = 0; i < 10; i++) word_q.push_back(8'($urandom));
        run_words(100, 1'b1, 1000, cyc);
        n_checks++;
        if (cyc !== 10 * FL + 1) $display("FAIL random_b2b_cycles got %0d want %0d", cyc, 10 * FL + 1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_c1();
        test_stall();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 16: parallel word width in bits; legal range 2..64.
REQ-002 Parameter LSB_FIRST, default 1: 1 = bit 0 shifted first, 0 = bit DATA_WIDTH-1 shifted first.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 din  input  DATA_WIDTH  parallel word to serialise.
REQ-006 din_valid  input  1  din holds a valid word.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 dout  output  1  current serial bit.
REQ-009 dout_valid  output  1  dout holds a valid frame bit.
REQ-010 dout_last  output  1  dout is the final bit of the frame.
REQ-011 dout_ready  input  1  downstream consumes the dout bit this cycle.

Function
REQ-012 FSM states: IDLE (no frame held) and SHIFT (frame in progress); no other states.
REQ-013 Word accepted on a cycle with din_valid=1 and din_ready=1; din is captured into the shift register on that edge.
REQ-014 din_ready = 1 in IDLE; in SHIFT, din_ready = dout_valid AND dout_ready AND dout_last (combinational); otherwise 0.
REQ-015 Acceptance in IDLE moves the FSM to SHIFT; the first frame bit is on dout with dout_valid=1 in the next cycle (latency 1).
REQ-016 A bit transfers on a cycle with dout_valid=1 and dout_ready=1; the next bit is presented in the following cycle.
REQ-017 With dout_ready=0, dout, dout_valid, dout_last and all internal state hold unchanged.
REQ-018 Bit counter width is $clog2(frame length + 1); dout_last = 1 exactly when the counter indexes the final frame bit.
REQ-019 Final bit transferred and no acceptance that cycle: FSM returns to IDLE; dout_valid, dout_last and dout go to 0.
REQ-020 Final bit transferred and a word accepted in the same cycle: FSM stays in SHIFT and the new frame's first bit follows with no idle cycle.
REQ-021 din_valid while din_ready=0 is ignored; upstream holds din and din_valid until acceptance.
REQ-022 dout is 0 whenever dout_valid = 0.

Reset
REQ-023 resetn low asynchronously forces: FSM to IDLE; shift register and counter to 0; dout, dout_valid and dout_last to 0.
REQ-024 din_ready is 0 while resetn is low, and 1 in the first cycle after resetn deasserts.
REQ-025 Reset mid-frame discards the partial frame; no remaining bits are emitted after release.

Configuration
REQ-026 Macro PISO_STREAM_PARITY_EN defined: frame length is DATA_WIDTH+1; the appended final bit is the XOR of all DATA_WIDTH data bits (even parity), carrying dout_last=1.
REQ-027 Macro PISO_STREAM_PARITY_EN undefined: frame length is DATA_WIDTH; dout_last is on the final data bit; no parity logic is instantiated.

Verification
REQ-028 DATA_WIDTH=8, LSB_FIRST=1, din=8'hC1 accepted, dout_ready=1 -> dout 1,0,0,0,0,0,1,1 on cycles 1..8 after acceptance; dout_last only on cycle 8; IDLE on cycle 9.
REQ-029 DATA_WIDTH=8, LSB_FIRST=0, din=8'hC1 -> dout 1,1,0,0,0,0,0,1; din_ready=0 in cycles 1..7 and 1 only in cycle 8.
REQ-030 Words 8'hC1 then 8'h3C with din_valid held high, dout_ready=1 -> 16 consecutive valid bits, no gap; dout_last on bits 8 and 16.
REQ-031 8'hC1 with dout_ready=0 for 3 cycles while bit 2 (value 0) is on dout -> dout=0 and dout_valid=1 held for those 3 cycles; sequence otherwise unchanged.
REQ-032 resetn pulsed low for 1 cycle after bit 4 of 8'hC1 -> dout=0, dout_valid=0 immediately; din_ready=1 after release; no residual bits emitted.
REQ-033 PISO_STREAM_PARITY_EN defined, 8'hC1, LSB_FIRST=1 -> 9 bits 1,0,0,0,0,0,1,1,1; dout_last on bit 9 only.
